// File: rtl/fetch_unit_pkg.sv
// Shared parameters and helpers for the instruction-fetch front end.
// Imported by the queue, the memory-bus interface and the fetch unit.
package fetch_unit_pkg;

  localparam int unsigned FU_ADDR_WIDTH = 32;
  localparam int unsigned FU_INST_WIDTH = 32;
  localparam int unsigned FU_FQ_DEPTH   = 4;
  localparam logic [31:0] FU_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] RV_NOP        = 32'h0000_0013;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave). Responses return in request order.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FU_ADDR_WIDTH,
  parameter int unsigned INST_WIDTH = FU_INST_WIDTH
);

  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [INST_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );

endinterface : fetch_unit_if

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {pc, instruction} entries for the fetch unit.
// Synchronous clear, occupancy count, and a head port that reads 0 when empty.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = FU_FQ_DEPTH,
  localparam int unsigned CW   = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; validity comes from count_q and the head read is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Credit accounting upstream must never push into a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push_i && !clear_i && full));

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order requests, a small fetch
// queue, and flush/redirect handling that drops stale in-flight responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = FU_ADDR_WIDTH,
  parameter int unsigned           INST_WIDTH = FU_INST_WIDTH,
  parameter int unsigned           FQ_DEPTH   = FU_FQ_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(FU_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_unit_if.master          imem,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  system_flush,
  input  logic                  system_stall,
  input  logic                  source_not_ready,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [INST_WIDTH-1:0] instruction_out,
  output logic                  uop_valid_out
);

  localparam int unsigned CW = cnt_width(FQ_DEPTH);
  localparam int unsigned EW = ADDR_WIDTH + INST_WIDTH;
  localparam logic [CW:0] CREDITS = (CW+1)'(FQ_DEPTH);

  logic                  active_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

  logic                  kill, req_fire, rsp_drop, enq, deq, q_empty;
  logic [CW-1:0]         q_count;
  logic [CW:0]           credit_used;
  logic [EW-1:0]         head;
  logic [ADDR_WIDTH-1:0] head_pc, restart_pc;

  assign kill        = redirect_valid | system_flush;
  assign credit_used = {1'b0, q_count} + {1'b0, outstanding_q};

  // active_q keeps the request bus quiet while reset is asserted.
  assign imem.req_valid = active_q && !kill && (credit_used < CREDITS);
  assign imem.req_addr  = fetch_pc_q;
  assign req_fire       = imem.req_valid && imem.req_ready;

  assign rsp_drop = (drop_cnt_q != '0);
  assign enq      = imem.rsp_valid && !rsp_drop && !kill;

  assign head_pc         = head[EW-1 -: ADDR_WIDTH];
  assign pc_out          = head_pc;
  assign instruction_out = head[INST_WIDTH-1:0];
  assign uop_valid_out   = !q_empty && !kill;
  assign deq             = uop_valid_out && !system_stall && !source_not_ready;

  // A plain flush resumes from the oldest instruction not yet handed to decode.
  assign restart_pc = redirect_valid ? redirect_pc : (q_empty ? resp_pc_q : head_pc);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem.rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;

    if (imem.rsp_valid && rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    if (req_fire)                   fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
    if (enq)                        resp_pc_d  = resp_pc_q + ADDR_WIDTH'(4);

    if (kill) begin
      drop_cnt_d = outstanding_d;
      fetch_pc_d = restart_pc;
      resp_pc_d  = restart_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q      <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      active_q      <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (kill),
    .push_i      (enq),
    .push_data_i ({resp_pc_q, imem.rsp_data}),
    .pop_i       (deq),
    .head_o      (head),
    .count_o     (q_count),
    .empty_o     (q_empty)
  );

endmodule : fetch_unit
